window_seq_ctrl: RTL
====================

Name: window_seq_ctrl

Overview:
Sequencer for the 9-entry window register file used by the NPU datapath. On start, it accepts 9 elements from an upstream valid/ready stream and writes them into the window register at addresses 0..8. It then replays the window in address order to the downstream MAC over a valid/ready stream, flagging the last element. It pulses done and returns to idle.

Parameters:
ELEM_W, 8, width of one window element
WIN_SIZE, 9, number of window entries (load and replay length)
ADDR_W, 4, window address width; must satisfy 2^ADDR_W >= WIN_SIZE

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_start  in  1  begin one load+replay pass; sampled only in IDLE
in_valid  in  1  upstream element valid
in_data  in  ELEM_W  upstream element
in_ready  out  1  controller accepts in_data this cycle
win_wr_en  out  1  window register write enable
win_wr_addr  out  ADDR_W  window write address
win_wr_data  out  ELEM_W  window write data
win_rd_addr  out  ADDR_W  window read address
win_rd_data  in  ELEM_W  window read data, combinational from win_rd_addr
out_valid  out  1  replay element valid
out_data  out  ELEM_W  replay element
out_last  out  1  current replay element is address WIN_SIZE-1
out_ready  in  1  downstream accepts element
o_busy  out  1  high in LOAD and READ
o_done  out  1  one-cycle pulse at end of pass

Behaviour:
- States: IDLE, LOAD, READ, DONE. Counter cnt is ADDR_W bits wide.
- Reset: state=IDLE, cnt=0. All outputs are 0: in_ready, win_wr_en, win_wr_addr, win_rd_addr, out_valid, out_last, o_busy, o_done. win_wr_data follows in_data.
- IDLE: when i_start=1, cnt<=0 and state<=LOAD. When i_start=0, state stays IDLE. i_start in any other state is ignored (not queued).
- LOAD: in_ready=1. win_wr_en = in_valid & in_ready (combinational), win_wr_addr=cnt, win_wr_data=in_data.
  - Each handshake increments cnt.
  - A handshake at cnt=WIN_SIZE-1 sets cnt<=0 and state<=READ.
  - Cycles with no handshake hold cnt.
- READ: win_rd_addr=cnt, out_valid=1, out_data=win_rd_data (zero added latency), out_last=(cnt==WIN_SIZE-1).
  - out_ready=1 increments cnt.
  - out_ready=1 at the last element sets state<=DONE.
  - out_ready=0 holds cnt, out_data and out_last stable.
- DONE: o_done=1 for exactly one cycle, cnt<=0, state<=IDLE.
- o_busy = (state==LOAD) | (state==READ).
- The first replay element is presented the cycle after the last write. The window register write lands on that same edge, so the read-after-write is safe.
- Minimum pass length with continuous valid/ready: 1 (start) + WIN_SIZE + WIN_SIZE + 1 cycles.
- Reset asserted mid-pass aborts the pass: next cycle is IDLE with all outputs at reset values. Window contents are untouched, and no o_done is produced.
- in_valid while not in LOAD: in_ready=0, and the data is not consumed.

Optional Feature:
Macro WINSEQ_REUSE_EN.
- Defined: adds input port i_reuse (1 bit). i_start & i_reuse in IDLE goes directly to READ with cnt=0, skipping LOAD and replaying the previously loaded window (kernel reuse). i_start & ~i_reuse behaves as the base design.
- Not defined: the port is absent, and every start performs LOAD then READ.

Decomposition:
- Shared package npu_win_pkg holds:
  - state encoding typedef (IDLE=0, LOAD=1, READ=2, DONE=3)
  - constants WIN_SIZE_DEF=9, ELEM_W_DEF=8, ADDR_W_DEF=4
- The controller is a single module; no sub-module is needed.
- The top level instantiates window_seq_ctrl beside the window register and wires the win_* ports directly.

Test Plan:
- Reset then start; stream 3,1,5,2,4,2,5,1,3 with in_valid=1 and out_ready=1 -> 9 writes at addr 0..8. Replay out_data is 3,1,5,2,4,2,5,1,3, with out_last only on the 9th element. o_done pulses 20 cycles after start.
- Upstream bubbles (in_valid toggling 1,0,1,0...) -> cnt holds on gaps, exactly 9 writes, addresses contiguous 0..8.
- Downstream stall: out_ready=0 for 3 cycles at element 4 -> out_data=4 and win_rd_addr=4 held stable. No skipped or duplicated elements.
- i_start pulsed during LOAD and READ -> ignored. Exactly one o_done, and the controller is in IDLE afterward.
- i_rst asserted after 5 writes -> next cycle IDLE, all outputs 0, no o_done. A new start then reloads from addr 0.
- With WINSEQ_REUSE_EN: load 1..9, then start with i_reuse=1 -> no writes, replay 1..9, o_done 11 cycles after start.

Source files
------------

// File: rtl/npu_win_pkg.sv
// Shared definitions for the NPU window sequencer: state encoding and default sizing.
package npu_win_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } win_state_t;

    localparam int WIN_SIZE_DEF = 9;
    localparam int ELEM_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 4;

endpackage

// File: rtl/window_seq_ctrl.sv
// Load/replay sequencer for the 9-entry window register file.
// Optional kernel reuse (replay without reload) is enabled by defining WINSEQ_REUSE_EN.
module window_seq_ctrl
    import npu_win_pkg::*;
#(
    parameter int ELEM_W   = ELEM_W_DEF,
    parameter int WIN_SIZE = WIN_SIZE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
`ifdef WINSEQ_REUSE_EN
    input  logic              i_reuse,
`endif
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    output logic              in_ready,
    output logic              win_wr_en,
    output logic [ADDR_W-1:0] win_wr_addr,
    output logic [ELEM_W-1:0] win_wr_data,
    output logic [ADDR_W-1:0] win_rd_addr,
    input  logic [ELEM_W-1:0] win_rd_data,
    output logic              out_valid,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIN_SIZE - 1);

    if ((1 << ADDR_W) < WIN_SIZE) begin : g_addr_w_check
        $error("ADDR_W too narrow for WIN_SIZE");
    end

    win_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        in_ready    = 1'b0;
        win_wr_en   = 1'b0;
        win_wr_addr = '0;
        win_wr_data = in_data;
        win_rd_addr = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    cnt_nxt = '0;
`ifdef WINSEQ_REUSE_EN
                    state_nxt = i_reuse ? ST_READ : ST_LOAD;
`else
                    state_nxt = ST_LOAD;
`endif
                end
            end

            ST_LOAD: begin
                in_ready    = 1'b1;
                o_busy      = 1'b1;
                win_wr_addr = cnt;
                win_wr_en   = in_valid;
                if (in_valid) begin
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_READ;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            // Read data comes straight from the register file; the last write
            // lands on the same edge that enters this state.
            ST_READ: begin
                o_busy      = 1'b1;
                out_valid   = 1'b1;
                win_rd_addr = cnt;
                out_data    = win_rd_data;
                out_last    = (cnt == LAST_IDX);
                if (out_ready) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                o_done    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
